// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I core sequencer:
// one-hot state encodings, bit indices and counter defaults.
package cpu_pkg;

    localparam int STATE_W    = 9;
    localparam int PERF_W_DEF = 32;

    localparam int IDX_INIT = 0;
    localparam int IDX_IF   = 1;
    localparam int IDX_IW   = 2;
    localparam int IDX_ID   = 3;
    localparam int IDX_EX   = 4;
    localparam int IDX_ST   = 5;
    localparam int IDX_LD   = 6;
    localparam int IDX_RDW  = 7;
    localparam int IDX_WB   = 8;

    typedef enum logic [STATE_W-1:0] {
        S_INIT = 9'b000000001,
        S_IF   = 9'b000000010,
        S_IW   = 9'b000000100,
        S_ID   = 9'b000001000,
        S_EX   = 9'b000010000,
        S_ST   = 9'b000100000,
        S_LD   = 9'b001000000,
        S_RDW  = 9'b010000000,
        S_WB   = 9'b100000000
    } state_e;

endpackage

// File: rtl/multicycle_fsm_if.sv
// Instruction/data memory valid-ready handshakes of the sequencer.
// master = sequencer side, slave = memory side.
interface multicycle_fsm_if;

    logic inst_req_valid;
    logic inst_req_ready;
    logic inst_valid;
    logic inst_ready;
    logic mem_read;
    logic mem_write;
    logic mem_req_ready;
    logic read_data_valid;
    logic read_data_ready;

    modport master (
        output inst_req_valid,
        input  inst_req_ready,
        input  inst_valid,
        output inst_ready,
        output mem_read,
        output mem_write,
        input  mem_req_ready,
        input  read_data_valid,
        output read_data_ready
    );

    modport slave (
        input  inst_req_valid,
        output inst_req_ready,
        output inst_valid,
        input  inst_ready,
        input  mem_read,
        input  mem_write,
        output mem_req_ready,
        output read_data_valid,
        input  read_data_ready
    );

endinterface

// File: rtl/perf_counter.sv
// Free-running enable/clear counter, wraps modulo 2^W.
// Synchronous active-high clear.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) count_d = count_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_fsm.sv
// Main sequencing FSM of the multi-cycle RV32I core.
// Optional performance counters enabled with macro PERF_CNT_EN.
module multicycle_fsm
    import cpu_pkg::*;
`ifdef PERF_CNT_EN
#(
    parameter int PERF_W = PERF_W_DEF
)
`endif
(
    input  logic               clk,
    input  logic               rst,
    input  logic               op_load,
    input  logic               op_store,
    input  logic               op_branch,
    input  logic               op_wb,
    multicycle_fsm_if.master   bus,
    output logic               ir_write,
    output logic               pc_write,
    output logic               reg_write,
`ifdef PERF_CNT_EN
    output logic [PERF_W-1:0]  cycle_cnt,
    output logic [PERF_W-1:0]  inst_cnt,
`endif
    output logic [STATE_W-1:0] state
);

    state_e state_q;
    state_e state_d;

    // Branches share the fall-through path back to fetch.
    logic unused_op_branch;
    assign unused_op_branch = op_branch;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_INIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d             = state_q;
        bus.inst_req_valid  = 1'b0;
        bus.inst_ready      = 1'b0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.read_data_ready = 1'b0;
        ir_write            = 1'b0;
        pc_write            = 1'b0;
        reg_write           = 1'b0;
        case (state_q)
            S_INIT: state_d = S_IF;
            S_IF: begin
                bus.inst_req_valid = 1'b1;
                if (bus.inst_req_ready) state_d = S_IW;
            end
            S_IW: begin
                bus.inst_ready = 1'b1;
                ir_write       = bus.inst_valid;
                if (bus.inst_valid) state_d = S_ID;
            end
            S_ID: state_d = S_EX;
            S_EX: begin
                pc_write = 1'b1;
                if      (op_load)  state_d = S_LD;
                else if (op_store) state_d = S_ST;
                else if (op_wb)    state_d = S_WB;
                else               state_d = S_IF;
            end
            S_ST: begin
                bus.mem_write = 1'b1;
                if (bus.mem_req_ready) state_d = S_IF;
            end
            S_LD: begin
                bus.mem_read = 1'b1;
                if (bus.mem_req_ready) state_d = S_RDW;
            end
            S_RDW: begin
                bus.read_data_ready = 1'b1;
                if (bus.read_data_valid) state_d = S_WB;
            end
            S_WB: begin
                reg_write = 1'b1;
                state_d   = S_IF;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign state = state_q;

`ifdef PERF_CNT_EN
    perf_counter #(.W(PERF_W)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .count (cycle_cnt)
    );

    perf_counter #(.W(PERF_W)) u_inst_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == S_EX),
        .count (inst_cnt)
    );
`endif

endmodule

// File: tb/tb_multicycle_fsm.sv
// Bench for multicycle_fsm: directed vectors,
// hand sequences and random handshakes vs model.
module tb_multicycle_fsm;
  import cpu_pkg::*;

  localparam logic [7:0] O_IRV = 8'h80;
  localparam logic [7:0] O_IR  = 8'h40;
  localparam logic [7:0] O_MR  = 8'h20;
  localparam logic [7:0] O_MW  = 8'h10;
  localparam logic [7:0] O_RDR = 8'h08;
  localparam logic [7:0] O_IRW = 8'h04;
  localparam logic [7:0] O_PC  = 8'h02;
  localparam logic [7:0] O_RW  = 8'h01;

  logic clk = 1'b0;
  logic rst;
  logic op_load, op_store, op_branch, op_wb;
  logic ir_write, pc_write, reg_write;
  logic [STATE_W-1:0] state;
`ifdef PERF_CNT_EN
  logic [3:0] cycle_cnt, inst_cnt;
`endif

  multicycle_fsm_if bus ();

`ifdef PERF_CNT_EN
  multicycle_fsm #(.PERF_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .op_load   (op_load),
    .op_store  (op_store),
    .op_branch (op_branch),
    .op_wb     (op_wb),
    .bus       (bus),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .cycle_cnt (cycle_cnt),
    .inst_cnt  (inst_cnt),
    .state     (state)
  );
`else
  multicycle_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .op_load   (op_load),
    .op_store  (op_store),
    .op_branch (op_branch),
    .op_wb     (op_wb),
    .bus       (bus),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .state     (state)
  );
`endif

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] ops;
    logic [3:0] hs;
    logic [8:0] es;
    logic [7:0] eo;
  } vec_t;

  vec_t vecs [13];

  task automatic set_in(
    input logic [3:0] ops,
    input logic [3:0] hs
  );
    {op_load, op_store, op_branch, op_wb} = ops;
    bus.inst_req_ready  = hs[3];
    bus.inst_valid      = hs[2];
    bus.mem_req_ready   = hs[1];
    bus.read_data_valid = hs[0];
  endtask

  function automatic logic [7:0] dut_out();
    return {bus.inst_req_valid, bus.inst_ready,
            bus.mem_read, bus.mem_write,
            bus.read_data_ready,
            ir_write, pc_write, reg_write};
  endfunction

  task automatic check_cycle(
    input logic [8:0] es,
    input logic [7:0] eo,
    input string nm
  );
    @(negedge clk);
    n_tests++;
    if ({state, dut_out()} !== {es, eo}) begin
      n_fail++;
      $display("FAIL %s: got %b/%b want %b/%b",
               nm, state, dut_out(), es, eo);
    end
    @(posedge clk);
    #1;
  endtask

  int cur;
  int plan [$];
  logic [3:0] m_cyc, m_inst;

  function automatic logic [7:0] model_out(
    input int ph,
    input logic iv
  );
    case (ph)
      IDX_IF:  return O_IRV;
      IDX_IW:  return iv ? (O_IR | O_IRW) : O_IR;
      IDX_EX:  return O_PC;
      IDX_ST:  return O_MW;
      IDX_LD:  return O_MR;
      IDX_RDW: return O_RDR;
      IDX_WB:  return O_RW;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input logic r);
    logic done;
    if (r) begin
      cur = IDX_INIT;
      plan.delete();
      m_cyc = 0;
      m_inst = 0;
      return;
    end
    m_cyc++;
    case (cur)
      IDX_IF:  done = bus.inst_req_ready;
      IDX_IW:  done = bus.inst_valid;
      IDX_ST:  done = bus.mem_req_ready;
      IDX_LD:  done = bus.mem_req_ready;
      IDX_RDW: done = bus.read_data_valid;
      default: done = 1'b1;
    endcase
    if (cur == IDX_EX) begin
      m_inst++;
      if (op_load)
        plan = {IDX_LD, IDX_RDW, IDX_WB};
      else if (op_store)
        plan = {IDX_ST};
      else if (op_wb)
        plan = {IDX_WB};
      else
        plan.delete();
    end
    if (done) begin
      if (plan.size() == 0) begin
        cur  = IDX_IF;
        plan = {IDX_IW, IDX_ID, IDX_EX};
      end else begin
        cur = plan.pop_front();
      end
    end
  endtask

  initial begin
    logic [8:0] one;
    logic [8:0] es;
    logic [7:0] eo;
    one = 9'd1;

    vecs[0]  = '{1'b1, 4'b0001, 4'hF, S_INIT, 8'h00};
    vecs[1]  = '{1'b1, 4'b0001, 4'hF, S_INIT, 8'h00};
    vecs[2]  = '{1'b0, 4'b0001, 4'hF, S_INIT, 8'h00};
    vecs[3]  = '{1'b0, 4'b0001, 4'hF, S_IF, O_IRV};
    vecs[4]  = '{1'b0, 4'b0001, 4'hF, S_IW,
                 O_IR | O_IRW};
    vecs[5]  = '{1'b0, 4'b0001, 4'hF, S_ID, 8'h00};
    vecs[6]  = '{1'b0, 4'b0001, 4'hF, S_EX, O_PC};
    vecs[7]  = '{1'b0, 4'b0001, 4'hF, S_WB, O_RW};
    vecs[8]  = '{1'b0, 4'b0010, 4'hF, S_IF, O_IRV};
    vecs[9]  = '{1'b0, 4'b0010, 4'hF, S_IW,
                 O_IR | O_IRW};
    vecs[10] = '{1'b0, 4'b0010, 4'hF, S_ID, 8'h00};
    vecs[11] = '{1'b0, 4'b0010, 4'hF, S_EX, O_PC};
    vecs[12] = '{1'b0, 4'b0010, 4'hF, S_IF, O_IRV};

    rst = 1'b1;
    set_in(4'b0001, 4'hF);
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      set_in(vecs[i].ops, vecs[i].hs);
      check_cycle(vecs[i].es, vecs[i].eo,
                  $sformatf("vec%0d", i));
    end
`ifdef PERF_CNT_EN
    @(negedge clk);
    n_tests++;
    if (inst_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL inst_cnt: got %0d want 2",
               inst_cnt);
    end
    @(posedge clk);
    #1;
`endif

    set_in(4'b1000, 4'hF);
    check_cycle(S_IW, O_IR | O_IRW, "lw_iw");
    check_cycle(S_ID, 8'h00, "lw_id");
    check_cycle(S_EX, O_PC, "lw_ex");
    set_in(4'b1000, 4'b1101);
    for (int k = 0; k < 3; k++)
      check_cycle(S_LD, O_MR, "lw_ld_wait");
    set_in(4'b1000, 4'b1110);
    check_cycle(S_LD, O_MR, "lw_ld_acc");
    set_in(4'b1000, 4'b1100);
    for (int k = 0; k < 2; k++)
      check_cycle(S_RDW, O_RDR, "lw_rdw_wait");
    set_in(4'b1000, 4'hF);
    check_cycle(S_RDW, O_RDR, "lw_rdw_acc");
    check_cycle(S_WB, O_RW, "lw_wb");
    check_cycle(S_IF, O_IRV, "lw_if");

    set_in(4'b0100, 4'hF);
    check_cycle(S_IW, O_IR | O_IRW, "sw_iw");
    check_cycle(S_ID, 8'h00, "sw_id");
    check_cycle(S_EX, O_PC, "sw_ex");
    set_in(4'b0100, 4'b1101);
    check_cycle(S_ST, O_MW, "sw_st_wait");
    rst = 1'b1;
    check_cycle(S_ST, O_MW, "sw_st_rst");
    rst = 1'b0;
    set_in(4'b0000, 4'hF);
    check_cycle(S_INIT, 8'h00, "sw_init");
    check_cycle(S_IF, O_IRV, "sw_refetch");
    check_cycle(S_IW, O_IR | O_IRW, "sw_iw2");

`ifdef PERF_CNT_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (cycle_cnt !== 4'd4) begin
      n_fail++;
      $display("FAIL cycle_cnt_wrap: got %0d want 4",
               cycle_cnt);
    end
`endif

    rst = 1'b1;
    @(posedge clk);
    model_step(1'b1);
    #1;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      set_in(4'($urandom_range(0, 15)),
             {($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 9) < 6)});
      @(negedge clk);
      es = one << cur;
      eo = model_out(cur, bus.inst_valid);
      n_tests++;
      if ({state, dut_out()} !== {es, eo}) begin
        n_fail++;
        $display("FAIL rand%0d: got %b/%b want %b/%b",
                 n, state, dut_out(), es, eo);
      end
`ifdef PERF_CNT_EN
      n_tests++;
      if ({cycle_cnt, inst_cnt} !==
          {m_cyc, m_inst}) begin
        n_fail++;
        $display("FAIL rand_cnt%0d: %0d/%0d vs %0d/%0d",
                 n, cycle_cnt, inst_cnt,
                 m_cyc, m_inst);
      end
`endif
      @(posedge clk);
      model_step(rst);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
